execute_unit: RTL and testbench
===============================

Name: execute_unit

Overview:
- Consumer end of the decoded-instruction interface that the control path drives.
- Takes op_code, the source/destination fields, the choice selects and push/pop; resolves operands, runs the ALU, writes the register file or output port, and registers zero_flag back to the control path.
- Owns the register-frame stack. A push saves the whole register file and a pop restores it, one register per cycle. busy tells the control path to stall the pc.

Parameters:
- OPCODE_WIDTH, 4, op_code width.
- VALUE_WIDTH, 8, data width; also the width of source1/source2/destination fields.
- REG_COUNT, 8, number of general registers; register index = field[$clog2(REG_COUNT)-1:0].
- STACK_DEPTH, 4, number of saved register frames.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- op_code  in  OPCODE_WIDTH  ALU operation
- source1  in  VALUE_WIDTH  register index or immediate, operand A
- source2  in  VALUE_WIDTH  register index or immediate, operand B
- destination  in  VALUE_WIDTH  destination register index
- source1_choice  in  2  operand A select
- source2_choice  in  2  operand B select
- destination_choice  in  2  result sink select
- push  in  1  save register frame
- pop  in  1  restore register frame
- zero_flag  out  1  registered: last flag-affecting result == 0
- busy  out  1  frame copy in progress; inputs ignored
- out_data  out  VALUE_WIDTH  output port register
- out_valid  out  1  one-cycle pulse when out_data written
- stack_err  out  1  sticky overflow/underflow/conflict flag

Behaviour:
- Fixed: one clock; reset is synchronous and active-high.
- Reset values:
  - all registers 0
  - stack pointer 0 (empty)
  - state IDLE
  - zero_flag 0, busy 0, out_data 0, out_valid 0, stack_err 0
- Choice encoding:
  - Operand select: 00 register[idx], 01 immediate (field value), 10/11 constant 0.
  - Destination select: 00 register[idx], 01 out_data, 10/11 discard.
- Opcodes (others are NOP):
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
  - 6 NOT A
  - 7 SHL A by 1, 8 SHR A by 1 (logical)
  - 9 MOV A
  - 10 CMP (A-B, flag only, no write)
- Arithmetic:
  - modulo 2^VALUE_WIDTH; carries dropped.
- Latency, IDLE state, no push/pop:
  - Operands are read combinationally.
  - Result is written at the next rising edge.
  - zero_flag updates at the same edge for opcodes 1-10; NOP holds zero_flag.
  - out_valid pulses for exactly the cycle after a write with destination_choice=01.
- Register forwarding:
  - Source reads in the same cycle as a write see the old value; the write lands at the edge.
- State machine IDLE / PUSHING / POPPING:
  - IDLE, push=1, pop=0, stack not full -> PUSHING, copy index 0.
    - Each cycle copies reg[i] into frame[sp].slot[i].
    - After REG_COUNT cycles, sp++ and return to IDLE.
  - IDLE, pop=1, push=0, stack not empty -> POPPING.
    - Each cycle copies frame[sp-1].slot[i] into reg[i].
    - After REG_COUNT cycles, sp-- and return to IDLE.
  - busy=1 for exactly REG_COUNT cycles, starting the cycle after acceptance.
  - zero_flag holds throughout.
- Acceptance cycle:
  - The ALU op presented with push/pop is suppressed; no write, no flag update.
  - All inputs are ignored while busy=1.
- Boundary conditions:
  - push with sp==STACK_DEPTH: ignored, stack_err<=1.
  - pop with sp==0: ignored, stack_err<=1.
  - push and pop together: both ignored, ALU op suppressed, stack_err<=1.
  - stack_err clears only on rst.
  - rst mid-copy: returns to IDLE next edge, sp=0, registers 0; partially written frame is discarded.
  - Register index ≥ REG_COUNT is impossible by truncation; upper field bits are ignored for register selects.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams
  - operand/destination choice encodings
  - the state enum
  - default widths shared with the control path
- One sub-module, alu_unit: combinational (op, a, b) -> (result, writes_dest, affects_flag).
- Register file and stack array stay inline in execute_unit.

Test Plan:
- Reset value: assert rst 2 cycles -> all outputs 0; then MOV reg1<-imm 0 (src1_choice=01, dest_choice=00) -> zero_flag=1 next cycle.
- ALU writes and flag: MOV r1<-5; MOV r2<-3; SUB r3=r1-r2 -> r3=2, zero_flag=0. Then CMP r3,imm 2 -> zero_flag=1, r3 unchanged. ADD imm 0xFF + imm 1 to out_data -> out_data=0x00, out_valid pulse 1 cycle, zero_flag=1.
- Push/pop round trip: load r0..r7=0x10..0x17; push -> busy high exactly 8 cycles. Overwrite r0..r7=0; pop -> after 8 busy cycles r0..r7=0x10..0x17. Ops presented during busy have no effect.
- Stack overflow and underflow: 4 pushes then a 5th -> 5th ignored, stack_err=1, busy stays 0. After rst, pop on empty stack -> ignored, stack_err=1.
- Conflict case: push=pop=1 together with ADD r1 -> r1 unchanged, state IDLE, stack_err=1.
- Reset mid-copy: rst asserted on the 3rd cycle of PUSHING -> next cycle busy=0, sp=0. A following pop -> stack_err=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Opcodes, select encodings, FSM states and default widths shared
//            by the control path and the execute unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int C_OPCODE_WIDTH = 4;
  localparam int C_VALUE_WIDTH  = 8;
  localparam int C_REG_COUNT    = 8;
  localparam int C_STACK_DEPTH  = 4;

  localparam logic [3:0] C_OP_NOP = 4'd0;
  localparam logic [3:0] C_OP_ADD = 4'd1;
  localparam logic [3:0] C_OP_SUB = 4'd2;
  localparam logic [3:0] C_OP_AND = 4'd3;
  localparam logic [3:0] C_OP_OR  = 4'd4;
  localparam logic [3:0] C_OP_XOR = 4'd5;
  localparam logic [3:0] C_OP_NOT = 4'd6;
  localparam logic [3:0] C_OP_SHL = 4'd7;
  localparam logic [3:0] C_OP_SHR = 4'd8;
  localparam logic [3:0] C_OP_MOV = 4'd9;
  localparam logic [3:0] C_OP_CMP = 4'd10;

  // Operand selects: 10/11 both give constant zero.
  localparam logic [1:0] C_SEL_REG = 2'b00;
  localparam logic [1:0] C_SEL_IMM = 2'b01;

  // Destination selects: 10/11 both discard the result.
  localparam logic [1:0] C_DST_REG = 2'b00;
  localparam logic [1:0] C_DST_OUT = 2'b01;

  typedef logic [1:0] state_t;
  localparam state_t C_ST_IDLE    = 2'd0;
  localparam state_t C_ST_PUSHING = 2'd1;
  localparam state_t C_ST_POPPING = 2'd2;

endpackage

`default_nettype wire

// File: rtl/alu_unit.sv
// ============================================================================
// Module   : alu_unit
// Purpose  : Combinational ALU; reports whether the op writes and sets flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_unit
  import cpu_pkg::*;
#(
  parameter int OPCODE_WIDTH = C_OPCODE_WIDTH,
  parameter int VALUE_WIDTH  = C_VALUE_WIDTH
) (
  input  logic [OPCODE_WIDTH-1:0] op,
  input  logic [VALUE_WIDTH-1:0]  a,
  input  logic [VALUE_WIDTH-1:0]  b,
  output logic [VALUE_WIDTH-1:0]  result,
  output logic                    writes_dest,
  output logic                    affects_flag
);

  always_comb begin
    result       = '0;
    writes_dest  = 1'b1;
    affects_flag = 1'b1;
    case (op)
      OPCODE_WIDTH'(C_OP_ADD): result = a + b;
      OPCODE_WIDTH'(C_OP_SUB): result = a - b;
      OPCODE_WIDTH'(C_OP_AND): result = a & b;
      OPCODE_WIDTH'(C_OP_OR):  result = a | b;
      OPCODE_WIDTH'(C_OP_XOR): result = a ^ b;
      OPCODE_WIDTH'(C_OP_NOT): result = ~a;
      OPCODE_WIDTH'(C_OP_SHL): result = a << 1;
      OPCODE_WIDTH'(C_OP_SHR): result = a >> 1;
      OPCODE_WIDTH'(C_OP_MOV): result = a;
      OPCODE_WIDTH'(C_OP_CMP): begin
        result      = a - b;
        writes_dest = 1'b0;
      end
      default: begin
        writes_dest  = 1'b0;
        affects_flag = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/execute_unit.sv
// ============================================================================
// Module   : execute_unit
// Purpose  : Operand resolve, ALU, register file, output port and the
//            register-frame stack copied one register per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_unit
  import cpu_pkg::*;
#(
  parameter int OPCODE_WIDTH = C_OPCODE_WIDTH,
  parameter int VALUE_WIDTH  = C_VALUE_WIDTH,
  parameter int REG_COUNT    = C_REG_COUNT,
  parameter int STACK_DEPTH  = C_STACK_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] op_code,
  input  logic [VALUE_WIDTH-1:0]  source1,
  input  logic [VALUE_WIDTH-1:0]  source2,
  input  logic [VALUE_WIDTH-1:0]  destination,
  input  logic [1:0]              source1_choice,
  input  logic [1:0]              source2_choice,
  input  logic [1:0]              destination_choice,
  input  logic                    push,
  input  logic                    pop,
  output logic                    zero_flag,
  output logic                    busy,
  output logic [VALUE_WIDTH-1:0]  out_data,
  output logic                    out_valid,
  output logic                    stack_err
);

  localparam int IDX_W = $clog2(REG_COUNT);
  localparam int FRM_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);

  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(REG_COUNT - 1);
  localparam logic [SP_W-1:0]  C_FULL_SP  = SP_W'(STACK_DEPTH);

  logic [VALUE_WIDTH-1:0] r_regs  [REG_COUNT];
  logic [VALUE_WIDTH-1:0] r_stack [STACK_DEPTH][REG_COUNT];
  logic [SP_W-1:0]        r_sp;
  state_t                 r_state;
  logic [IDX_W-1:0]       r_idx;

  logic [IDX_W-1:0]       w_s1_idx;
  logic [IDX_W-1:0]       w_s2_idx;
  logic [IDX_W-1:0]       w_dst_idx;
  logic [VALUE_WIDTH-1:0] w_a;
  logic [VALUE_WIDTH-1:0] w_b;
  logic [VALUE_WIDTH-1:0] w_result;
  logic                   w_writes;
  logic                   w_flag;
  logic [SP_W-1:0]        w_sp_dec;
  logic [FRM_W-1:0]       w_push_frame;
  logic [FRM_W-1:0]       w_pop_frame;
  logic                   w_stack_fault;
  logic                   w_unused;

  assign w_s1_idx  = source1[IDX_W-1:0];
  assign w_s2_idx  = source2[IDX_W-1:0];
  assign w_dst_idx = destination[IDX_W-1:0];

  assign w_sp_dec     = r_sp - SP_W'(1);
  assign w_push_frame = r_sp[FRM_W-1:0];
  assign w_pop_frame  = w_sp_dec[FRM_W-1:0];

  // Upper destination bits never select a register.
  assign w_unused = ^{destination, w_sp_dec};

  assign busy = (r_state != C_ST_IDLE);

  assign w_stack_fault = (push && pop)
                       || (push && (r_sp == C_FULL_SP))
                       || (pop  && (r_sp == '0));

  always_comb begin
    case (source1_choice)
      C_SEL_REG: w_a = r_regs[w_s1_idx];
      C_SEL_IMM: w_a = source1;
      default:   w_a = '0;
    endcase
    case (source2_choice)
      C_SEL_REG: w_b = r_regs[w_s2_idx];
      C_SEL_IMM: w_b = source2;
      default:   w_b = '0;
    endcase
  end

  alu_unit #(
    .OPCODE_WIDTH (OPCODE_WIDTH),
    .VALUE_WIDTH  (VALUE_WIDTH)
  ) u_alu (
    .op           (op_code),
    .a            (w_a),
    .b            (w_b),
    .result       (w_result),
    .writes_dest  (w_writes),
    .affects_flag (w_flag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
      r_sp      <= '0;
      r_state   <= C_ST_IDLE;
      r_idx     <= '0;
      zero_flag <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        C_ST_IDLE: begin
          if (push || pop) begin
            // Any push/pop request suppresses the ALU op in this cycle.
            if (w_stack_fault) begin
              stack_err <= 1'b1;
            end else if (push) begin
              r_state <= C_ST_PUSHING;
              r_idx   <= '0;
            end else begin
              r_state <= C_ST_POPPING;
              r_idx   <= '0;
            end
          end else begin
            if (w_flag) begin
              zero_flag <= (w_result == '0);
            end
            if (w_writes) begin
              case (destination_choice)
                C_DST_REG: r_regs[w_dst_idx] <= w_result;
                C_DST_OUT: begin
                  out_data  <= w_result;
                  out_valid <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        C_ST_PUSHING: begin
          if (r_idx == C_LAST_IDX) begin
            r_sp    <= r_sp + 1'b1;
            r_state <= C_ST_IDLE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        C_ST_POPPING: begin
          r_regs[r_idx] <= r_stack[w_pop_frame][r_idx];
          if (r_idx == C_LAST_IDX) begin
            r_sp    <= w_sp_dec;
            r_state <= C_ST_IDLE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= C_ST_IDLE;
      endcase
    end
  end

  // Frame storage needs no reset: a frame only becomes visible once sp covers it.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == C_ST_PUSHING)) begin
      r_stack[w_push_frame][r_idx] <= r_regs[r_idx];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_execute_unit.sv
// ============================================================================
// Module   : tb_execute_unit
// Purpose  : Randomized and directed self-checking bench for execute_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] op_code = '0;
  logic [7:0] source1 = '0;
  logic [7:0] source2 = '0;
  logic [7:0] destination = '0;
  logic [1:0] source1_choice = '0;
  logic [1:0] source2_choice = '0;
  logic [1:0] destination_choice = '0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       zero_flag;
  logic       busy;
  logic [7:0] out_data;
  logic       out_valid;
  logic       stack_err;

  always #5 clk = ~clk;

  execute_unit #(
    .OPCODE_WIDTH (4),
    .VALUE_WIDTH  (8),
    .REG_COUNT    (8),
    .STACK_DEPTH  (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .op_code            (op_code),
    .source1            (source1),
    .source2            (source2),
    .destination        (destination),
    .source1_choice     (source1_choice),
    .source2_choice     (source2_choice),
    .destination_choice (destination_choice),
    .push               (push),
    .pop                (pop),
    .zero_flag          (zero_flag),
    .busy               (busy),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .stack_err          (stack_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: architectural registers plus a list of saved frames.
  logic [7:0]  m_regs [8];
  logic [63:0] m_stack [$];
  int          m_busy_left;
  bit          m_pushing;
  logic        m_zero;
  logic        m_err;
  logic        m_ov;
  logic [7:0]  m_out;
  bit          g_rst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] opnd(input logic [1:0] c, input logic [7:0] f);
    if (c == 2'b00) return m_regs[int'(f) % 8];
    if (c == 2'b01) return f;
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_stack.delete();
    m_busy_left = 0;
    m_pushing   = 0;
    m_zero      = 1'b0;
    m_err       = 1'b0;
    m_ov        = 1'b0;
    m_out       = 8'h00;
  endtask

  task automatic step(input logic [3:0] op, input logic [7:0] s1, input logic [7:0] s2,
                      input logic [7:0] d, input logic [1:0] c1, input logic [1:0] c2,
                      input logic [1:0] cd, input logic pu, input logic po);
    logic [7:0]  a, b, res;
    logic [63:0] fr;
    bit          wr, fl;
    @(negedge clk);
    rst = g_rst; op_code = op; source1 = s1; source2 = s2; destination = d;
    source1_choice = c1; source2_choice = c2; destination_choice = cd;
    push = pu; pop = po;
    a = opnd(c1, s1);
    b = opnd(c2, s2);
    @(posedge clk);
    m_ov = 1'b0;
    if (g_rst) begin
      model_reset();
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) begin
        if (m_pushing) begin
          for (int i = 0; i < 8; i++) fr[i*8 +: 8] = m_regs[i];
          m_stack.push_back(fr);
        end else begin
          fr = m_stack.pop_back();
          for (int i = 0; i < 8; i++) m_regs[i] = fr[i*8 +: 8];
        end
      end
    end else if (pu && po) begin
      m_err = 1'b1;
    end else if (pu) begin
      if (m_stack.size() == 4) m_err = 1'b1;
      else begin m_busy_left = 8; m_pushing = 1; end
    end else if (po) begin
      if (m_stack.size() == 0) m_err = 1'b1;
      else begin m_busy_left = 8; m_pushing = 0; end
    end else begin
      wr = 1; fl = 1;
      case (op)
        4'd1:  res = a + b;
        4'd2:  res = a - b;
        4'd3:  res = a & b;
        4'd4:  res = a | b;
        4'd5:  res = a ^ b;
        4'd6:  res = ~a;
        4'd7:  res = a << 1;
        4'd8:  res = a >> 1;
        4'd9:  res = a;
        4'd10: begin res = a - b; wr = 0; end
        default: begin res = 8'h00; wr = 0; fl = 0; end
      endcase
      if (fl) m_zero = (res == 8'h00);
      if (wr) begin
        if (cd == 2'b00) m_regs[int'(d) % 8] = res;
        else if (cd == 2'b01) begin m_out = res; m_ov = 1'b1; end
      end
    end
    #1;
    chk("busy", busy, (m_busy_left > 0));
    chk("zero_flag", zero_flag, m_zero);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_out);
    chk("stack_err", stack_err, m_err);
  endtask

  task automatic alu(input logic [3:0] op, input logic [7:0] s1, input logic [7:0] s2,
                     input logic [7:0] d, input logic [1:0] c1, input logic [1:0] c2,
                     input logic [1:0] cd);
    step(op, s1, s2, d, c1, c2, cd, 1'b0, 1'b0);
  endtask

  task automatic rnd_step(input int pct);
    logic [3:0] op = 4'($urandom_range(0, 15));
    logic       pu = ($urandom_range(0, 99) < pct);
    logic       po = ($urandom_range(0, 99) < pct);
    step(op, 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom),
         2'($urandom), pu, po);
  endtask

  task automatic do_reset();
    g_rst = 1'b1;
    rnd_step(20);
    rnd_step(20);
    g_rst = 1'b0;
  endtask

  // Reads a register through the output port, with random upper index bits.
  task automatic rd_reg(input int i, input logic [7:0] exp, input string tag);
    logic [7:0] f = ($urandom & 8'hF8) | 8'(i);
    alu(4'd9, f, 8'h00, 8'h00, 2'b00, 2'b10, 2'b01);
    chk(tag, out_data, exp);
  endtask

  // Issues push or pop and counts how long busy stays high; junk drives meanwhile.
  task automatic frame_op(input logic is_push, input string tag);
    int n = 0;
    step(4'd1, 8'h01, 8'h01, 8'h01, 2'b01, 2'b01, 2'b00, is_push, !is_push);
    for (int k = 0; k < 20; k++) begin
      if (!busy) break;
      rnd_step(50);
      n++;
    end
    chk(tag, n, 8);
  endtask

  initial begin
    g_rst = 1'b1;
    model_reset();
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_out", out_data, 0);
    chk("rst_err", stack_err, 0);

    alu(4'd9, 8'h00, 8'h00, 8'h01, 2'b01, 2'b10, 2'b00);
    chk("mov0_zero", zero_flag, 1);
    alu(4'd9, 8'h05, 8'h00, 8'h01, 2'b01, 2'b10, 2'b00);
    alu(4'd9, 8'h03, 8'h00, 8'h02, 2'b01, 2'b10, 2'b00);
    alu(4'd2, 8'h01, 8'h02, 8'h03, 2'b00, 2'b00, 2'b00);
    chk("sub_zero", zero_flag, 0);
    alu(4'd10, 8'h03, 8'h02, 8'h03, 2'b00, 2'b01, 2'b00);
    chk("cmp_zero", zero_flag, 1);
    rd_reg(3, 8'h02, "sub_r3");
    alu(4'd1, 8'hFF, 8'h01, 8'h00, 2'b01, 2'b01, 2'b01);
    chk("wrap_out", out_data, 8'h00);
    chk("wrap_valid", out_valid, 1);
    chk("wrap_zero", zero_flag, 1);
    alu(4'd0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b01);
    chk("valid_pulse", out_valid, 0);

    for (int i = 0; i < 8; i++) alu(4'd9, 8'h10 + 8'(i), 8'h00, 8'(i), 2'b01, 2'b10, 2'b00);
    frame_op(1'b1, "push_busy_len");
    for (int i = 0; i < 8; i++) alu(4'd9, 8'h00, 8'h00, 8'(i), 2'b01, 2'b10, 2'b00);
    frame_op(1'b0, "pop_busy_len");
    for (int i = 0; i < 8; i++) rd_reg(i, 8'h10 + 8'(i), "pop_reg");

    do_reset();
    for (int p = 0; p < 4; p++) frame_op(1'b1, "fill_busy_len");
    step(4'd0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    chk("ovf_busy", busy, 0);
    chk("ovf_err", stack_err, 1);

    do_reset();
    step(4'd0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    chk("unf_busy", busy, 0);
    chk("unf_err", stack_err, 1);

    do_reset();
    alu(4'd9, 8'h07, 8'h00, 8'h01, 2'b01, 2'b10, 2'b00);
    step(4'd1, 8'h01, 8'h01, 8'h01, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1);
    chk("conf_busy", busy, 0);
    chk("conf_err", stack_err, 1);
    rd_reg(1, 8'h07, "conf_r1");

    do_reset();
    alu(4'd9, 8'h55, 8'h00, 8'h00, 2'b01, 2'b10, 2'b00);
    step(4'd0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    rnd_step(0);
    rnd_step(0);
    g_rst = 1'b1;
    rnd_step(0);
    g_rst = 1'b0;
    chk("midrst_busy", busy, 0);
    step(4'd0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    chk("midrst_pop_err", stack_err, 1);
    chk("midrst_pop_busy", busy, 0);

    do_reset();
    for (int k = 0; k < 800; k++) rnd_step(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
